// File: rtl/bus_reader_pkg.sv
// ============================================================================
// bus_reader_pkg : shared state encoding and widths for bus-side register blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package bus_reader_pkg;

  localparam int BUS_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD1 = 2'd1,
    ST_HOLD2 = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bus_reader_flags.sv
// ============================================================================
// bus_reader_flags : bank of sticky fault flags, a set event beats a clear
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_reader_flags #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] set_evt,
  input  logic         clr,
  output logic [N-1:0] flags
);

  logic [N-1:0] flags_d;
  logic [N-1:0] flags_q;

  always_comb begin
    flags_d = clr ? '0 : flags_q;
    flags_d = flags_d | set_evt;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule

`default_nettype wire

// File: rtl/bus_reader.sv
// ============================================================================
// bus_reader : captures the shared tri-state bus into a 2-entry valid/ack queue
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_reader
  import bus_reader_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             bus_oe,
  input  logic             load_n,
  input  logic             ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             full,
  output logic             overrun,
  output logic             float_err
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] head_d, head_q;
  logic [WIDTH-1:0] tail_d, tail_q;
  logic             valid_d, valid_q;
  logic             full_d, full_q;

  logic             cap;
  logic             float_evt;
  logic             pop;
  logic             drop;
  logic [1:0]       flags;

  assign cap       = !load_n && bus_oe;
  assign float_evt = !load_n && !bus_oe;
  assign pop       = ack && valid_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    drop    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (cap) begin
          head_d  = bus;
          state_d = ST_HOLD1;
        end
      end
      ST_HOLD1: begin
        case ({cap, pop})
          2'b10: begin
            tail_d  = bus;
            state_d = ST_HOLD2;
          end
          2'b01: state_d = ST_EMPTY;
          2'b11: head_d  = bus;
          default: ;
        endcase
      end
      ST_HOLD2: begin
        case ({cap, pop})
          2'b01: begin
            head_d  = tail_q;
            state_d = ST_HOLD1;
          end
          2'b11: begin
            head_d = tail_q;
            tail_d = bus;
          end
          // Queue is full and nobody is draining: the incoming byte is lost.
          2'b10: drop = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Status outputs are flopped from the next state so they align with head_q.
  always_comb begin
    valid_d = (state_d != ST_EMPTY);
    full_d  = (state_d == ST_HOLD2);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  bus_reader_flags #(
    .N (2)
  ) u_flags (
    .clk     (clk),
    .clr_n   (clr_n),
    .set_evt ({drop, float_evt}),
    .clr     (err_clr),
    .flags   (flags)
  );

  assign data_out  = head_q;
  assign valid     = valid_q;
  assign full      = full_q;
  assign float_err = flags[0];
  assign overrun   = flags[1];

endmodule

`default_nettype wire

// File: tb/tb_bus_reader.sv
// ============================================================================
// tb_bus_reader : directed vector table plus reset corner sequences for bus_reader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bus_reader;

  typedef struct {
    logic [7:0] bus;
    logic       oe;
    logic       load_n;
    logic       ack;
    logic       err_clr;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_full;
    logic       e_ovr;
    logic       e_flt;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [7:0] bus = 8'h00;
  logic       bus_oe = 1'b1;
  logic       load_n = 1'b1;
  logic       ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       valid, full, overrun, float_err;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  bus_reader #(.WIDTH(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .bus       (bus),
    .bus_oe    (bus_oe),
    .load_n    (load_n),
    .ack       (ack),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .valid     (valid),
    .full      (full),
    .overrun   (overrun),
    .float_err (float_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] b, input logic oe, input logic ld_n,
                              input logic ak, input logic ec, input logic [7:0] d,
                              input logic v, input logic f, input logic o, input logic fl);
    vec_t r;
    r.bus = b; r.oe = oe; r.load_n = ld_n; r.ack = ak; r.err_clr = ec;
    r.e_data = d; r.e_valid = v; r.e_full = f; r.e_ovr = o; r.e_flt = fl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                           input logic f, input logic o, input logic fl);
    chk({tag, " data_out"},  data_out,            d);
    chk({tag, " valid"},     {7'd0, valid},       {7'd0, v});
    chk({tag, " full"},      {7'd0, full},        {7'd0, f});
    chk({tag, " overrun"},   {7'd0, overrun},     {7'd0, o});
    chk({tag, " float_err"}, {7'd0, float_err},   {7'd0, fl});
  endtask

  task automatic idle_inputs();
    bus = 8'h00; bus_oe = 1'b1; load_n = 1'b1; ack = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    //               bus    oe ld ak ec  data  v  f  o  fl
    vecs.push_back(mk(8'hA5, 1, 0, 0, 0, 8'hA5, 1, 0, 0, 0)); // single load
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'hA5, 0, 0, 0, 0)); // pop to empty
    vecs.push_back(mk(8'h11, 1, 0, 0, 0, 8'h11, 1, 0, 0, 0));
    vecs.push_back(mk(8'h22, 1, 0, 0, 0, 8'h11, 1, 1, 0, 0)); // full
    vecs.push_back(mk(8'h33, 1, 0, 0, 0, 8'h11, 1, 1, 1, 0)); // dropped
    vecs.push_back(mk(8'h00, 1, 1, 0, 1, 8'h11, 1, 1, 0, 0)); // clear overrun
    vecs.push_back(mk(8'h33, 1, 0, 0, 1, 8'h11, 1, 1, 1, 0)); // set beats clear
    vecs.push_back(mk(8'h00, 1, 1, 0, 1, 8'h11, 1, 1, 0, 0));
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h22, 1, 0, 0, 0)); // 33 never shows
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h22, 0, 0, 0, 0));
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h22, 0, 0, 0, 0)); // ack ignored in EMPTY
    vecs.push_back(mk(8'h44, 1, 0, 0, 0, 8'h44, 1, 0, 0, 0));
    vecs.push_back(mk(8'h55, 1, 0, 1, 0, 8'h55, 1, 0, 0, 0)); // HOLD1 cap+pop
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h55, 0, 0, 0, 0));
    vecs.push_back(mk(8'h44, 1, 0, 0, 0, 8'h44, 1, 0, 0, 0));
    vecs.push_back(mk(8'h55, 1, 0, 0, 0, 8'h44, 1, 1, 0, 0));
    vecs.push_back(mk(8'h66, 1, 0, 1, 0, 8'h55, 1, 1, 0, 0)); // HOLD2 cap+pop
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h66, 1, 0, 0, 0));
    vecs.push_back(mk(8'h00, 1, 1, 1, 0, 8'h66, 0, 0, 0, 0));
    vecs.push_back(mk(8'hFF, 0, 0, 0, 0, 8'h66, 0, 0, 0, 1)); // floating bus
    vecs.push_back(mk(8'hFF, 0, 0, 0, 1, 8'h66, 0, 0, 0, 1)); // set beats clear
    vecs.push_back(mk(8'h00, 1, 1, 0, 1, 8'h66, 0, 0, 0, 0));
    vecs.push_back(mk(8'h77, 1, 0, 0, 0, 8'h77, 1, 0, 0, 0));
    vecs.push_back(mk(8'hFF, 0, 0, 0, 0, 8'h77, 1, 0, 0, 1)); // float in HOLD1
    vecs.push_back(mk(8'h00, 1, 1, 1, 1, 8'h77, 0, 0, 0, 0));

    // Asynchronous reset must act before the first clock edge.
    idle_inputs();
    #2 clr_n = 1'b0;
    #1 check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus = vecs[i].bus; bus_oe = vecs[i].oe; load_n = vecs[i].load_n;
      ack = vecs[i].ack; err_clr = vecs[i].err_clr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                vecs[i].e_full, vecs[i].e_ovr, vecs[i].e_flt);
    end

    // Fill to HOLD2, then reset between edges; outputs must clear immediately.
    idle_inputs();
    bus = 8'h81; load_n = 1'b0;
    @(posedge clk); #1;
    bus = 8'h82;
    @(posedge clk); #1;
    check_all("prefill", 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    bus_oe = 1'b0; load_n = 1'b0; // raise float_err so the reset has a flag to clear
    @(posedge clk); #1;
    idle_inputs();
    check_all("prefill_flt", 8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 clr_n = 1'b0;
    #1 check_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    bus = 8'h9A; load_n = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst_load", 8'h9A, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    ack = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst_drain", 8'h9A, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
